// File: rtl/uart_cmd_responder_if.sv
// FIFO-side handshake between the uart block and the command responder.
// The responder is the master: it issues the pop/push strobes and the transmit byte.
interface uart_cmd_responder_if;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full;
  logic [7:0] w_data;
  logic       wr_uart;

  modport master (
    input  rx_empty,
    input  r_data,
    input  tx_full,
    output rd_uart,
    output w_data,
    output wr_uart
  );

  modport slave (
    output rx_empty,
    output r_data,
    output tx_full,
    input  rd_uart,
    input  w_data,
    input  wr_uart
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// Serial command responder: decodes 'W' addr data / 'R' addr frames popped from the uart
// receive FIFO, maintains a small register file and answers through the transmit FIFO.
module uart_cmd_responder #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned TO_W        = 20
) (
  input  logic                        clk,
  input  logic                        reset_n,
  uart_cmd_responder_if.master        fifo,
  output logic [7:0]                  reg0
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [7:0] CmdWrite  = 8'h57;  // 'W'
  localparam logic [7:0] CmdRead   = 8'h52;  // 'R'
  localparam logic [7:0] RspAck    = 8'h4B;  // 'K'
  localparam logic [7:0] RspBadCmd = 8'h3F;  // '?'
  localparam logic [7:0] RspTmo    = 8'h21;  // '!'

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StExec,
    StSend
  } state_e;

  state_e            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        resp_q, resp_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              pop_q;
  logic              pop;
  logic              push;
  logic              reg_we;
  logic              can_pop;
  logic [7:0]        regs_q [Depth];

  // A pop is only allowed with data present and never on two consecutive cycles.
  assign can_pop = !fifo.rx_empty && !pop_q;

  assign fifo.rd_uart = pop;
  assign fifo.wr_uart = push;
  // resp_q only changes when entering SEND, so it doubles as the held transmit byte.
  assign fifo.w_data  = resp_q;
  assign reg0         = regs_q[0];

  // Next-state, frame capture and strobe generation.
  always_comb begin
    state_d  = state_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    resp_d   = resp_q;
    to_cnt_d = to_cnt_q;
    pop      = 1'b0;
    push     = 1'b0;
    reg_we   = 1'b0;

    unique case (state_q)
      StIdle: begin
        to_cnt_d = '0;
        if (can_pop) begin
          pop = 1'b1;
          if (fifo.r_data == CmdWrite) begin
            is_wr_d = 1'b1;
            state_d = StGetAddr;
          end else if (fifo.r_data == CmdRead) begin
            is_wr_d = 1'b0;
            state_d = StGetAddr;
          end else begin
            resp_d  = RspBadCmd;
            state_d = StSend;
          end
        end
      end

      StGetAddr: begin
        if (can_pop) begin
          pop      = 1'b1;
          addr_d   = fifo.r_data[ADDR_W-1:0];
          to_cnt_d = '0;
          state_d  = is_wr_q ? StGetData : StExec;
        end else if (to_cnt_q == ToLast) begin
          resp_d  = RspTmo;
          state_d = StSend;
        end else if (fifo.rx_empty) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      StGetData: begin
        if (can_pop) begin
          pop      = 1'b1;
          data_d   = fifo.r_data;
          to_cnt_d = '0;
          state_d  = StExec;
        end else if (to_cnt_q == ToLast) begin
          // Abandon the frame; the pending write is dropped.
          resp_d  = RspTmo;
          state_d = StSend;
        end else if (fifo.rx_empty) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      StExec: begin
        if (is_wr_q) begin
          reg_we = 1'b1;
          resp_d = RspAck;
        end else begin
          resp_d = regs_q[addr_q];
        end
        state_d = StSend;
      end

      StSend: begin
        if (!fifo.tx_full) begin
          push     = 1'b1;
          to_cnt_d = '0;
          state_d  = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and frame registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= 8'h00;
      resp_q   <= 8'h00;
      to_cnt_q <= '0;
      pop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      resp_q   <= resp_d;
      to_cnt_q <= to_cnt_d;
      pop_q    <= pop;
    end
  end

  // Register file, written only from EXEC of a write frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (reg_we) begin
      regs_q[addr_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder with a behavioural receive FIFO and transmit logger.
module tb_uart_cmd_responder;

  localparam int unsigned ToCyc = 50;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_full = 1'b0;
  logic [7:0] reg0;

  // Receive FIFO model: the initial block owns wr_ptr/rx_mem, the monitor owns rd_ptr.
  logic [7:0] rx_mem [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  // Monitor state.
  logic       rd_s = 1'b0;
  logic       wr_s = 1'b0;
  logic       full_s = 1'b0;
  logic       prev_rd = 1'b0;
  logic [7:0] wd_s = 8'h00;
  logic [7:0] tx_log [32];
  int         lat [32];
  int         tx_cnt = 0;
  int         rd_cnt = 0;
  int         cyc = 0;
  int         last_pop = 0;
  int         consec_rd = 0;
  int         wr_full = 0;

  int         errors = 0;
  int         checks = 0;

  uart_cmd_responder_if fifo ();

  assign fifo.rx_empty = (rd_ptr == wr_ptr);
  assign fifo.r_data   = rx_mem[rd_ptr % 256];
  assign fifo.tx_full  = tx_full;

  uart_cmd_responder #(
    .ADDR_W      (4),
    .TIMEOUT_CYC (ToCyc),
    .TO_W        (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .fifo    (fifo),
    .reg0    (reg0)
  );

  always #5 clk = ~clk;

  // Sample strobes well away from the rising edge.
  always @(negedge clk) begin
    #2;
    rd_s   = fifo.rd_uart;
    wr_s   = fifo.wr_uart;
    wd_s   = fifo.w_data;
    full_s = fifo.tx_full;
  end

  // Apply the sampled strobes at the edge that consumes them.
  always @(posedge clk) begin
    cyc++;
    if (rd_s) begin
      rd_ptr++;
      rd_cnt++;
      last_pop = cyc;
      if (prev_rd) consec_rd++;
    end
    prev_rd = rd_s;
    if (wr_s) begin
      if (tx_cnt < 32) begin
        tx_log[tx_cnt] = wd_s;
        lat[tx_cnt]    = cyc - last_pop;
      end
      tx_cnt++;
      if (full_s) wr_full++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    rx_mem[wr_ptr % 256] = b;
    wr_ptr++;
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && tx_cnt < n; i++) @(negedge clk);
    chk(tag, tx_cnt, n);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int rd_base;

    // Reset state.
    reset_n = 1'b0;
    cycles(3);
    #3;
    chk("rst_reg0", reg0, 8'h00);
    chk("rst_rd_uart", fifo.rd_uart, 1'b0);
    chk("rst_wr_uart", fifo.wr_uart, 1'b0);
    chk("rst_w_data", fifo.w_data, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    // Write 0xA5 to register 0.
    cycles(2);
    put(8'h57); put(8'h00); put(8'hA5);
    wait_tx(1, 40, "w0_push_count");
    chk("w0_resp", tx_log[0], 8'h4B);
    chk("w0_reg0", reg0, 8'hA5);
    chk("w0_pops", rd_cnt, 3);
    chk("w0_latency", lat[0], 2);

    // Write reg 3, read back through aliased address 0x13, read unwritten 0x05.
    put(8'h57); put(8'h03); put(8'h3C); put(8'h52); put(8'h13);
    wait_tx(3, 60, "rw3_push_count");
    chk("w3_resp", tx_log[1], 8'h4B);
    chk("r13_alias", tx_log[2], 8'h3C);
    chk("r13_latency", lat[2], 2);
    put(8'h52); put(8'h05);
    wait_tx(4, 40, "r5_push_count");
    chk("r5_unwritten", tx_log[3], 8'h00);

    // Unknown command byte, then a normal read of reg 0.
    put(8'h41); put(8'h52); put(8'h00);
    wait_tx(6, 60, "bad_push_count");
    chk("bad_resp", tx_log[4], 8'h3F);
    chk("r0_after_bad", tx_log[5], 8'hA5);
    chk("pops_after_bad", rd_cnt, 13);

    // Incomplete write frame times out; register 1 stays clear.
    put(8'h57); put(8'h01);
    wait_tx(7, 200, "tmo_push_count");
    chk("tmo_resp", tx_log[6], 8'h21);
    chk("tmo_latency", lat[6], ToCyc + 1);
    put(8'h52); put(8'h01);
    wait_tx(8, 40, "r1_push_count");
    chk("r1_unchanged", tx_log[7], 8'h00);

    // Back-pressure: hold tx_full while the write response is pending.
    rd_base = rd_cnt;
    tx_full = 1'b1;
    put(8'h57); put(8'h02); put(8'h77); put(8'h52); put(8'h02);
    cycles(30);
    chk("bp_no_push", tx_cnt, 8);
    chk("bp_pops_held", rd_cnt, rd_base + 3);
    #3;
    chk("bp_wr_low", fifo.wr_uart, 1'b0);
    @(negedge clk);
    tx_full = 1'b0;
    wait_tx(10, 40, "bp_push_count");
    chk("bp_resp", tx_log[8], 8'h4B);
    chk("bp_read", tx_log[9], 8'h77);
    cycles(10);
    chk("bp_no_extra", tx_cnt, 10);

    // Reset in the middle of a write frame.
    put(8'h57); put(8'h00);
    cycles(6);
    reset_n = 1'b0;
    cycles(2);
    reset_n = 1'b1;
    cycles(10);
    chk("mid_rst_no_push", tx_cnt, 10);
    chk("mid_rst_reg0", reg0, 8'h00);
    put(8'h57); put(8'h00); put(8'h5A);
    wait_tx(11, 40, "post_rst_w_count");
    chk("post_rst_w_resp", tx_log[10], 8'h4B);
    chk("post_rst_reg0", reg0, 8'h5A);
    put(8'h52); put(8'h02);
    wait_tx(12, 40, "post_rst_r_count");
    chk("post_rst_r2_clear", tx_log[11], 8'h00);

    chk("no_consec_pops", consec_rd, 0);
    chk("no_push_when_full", wr_full, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
